obi_string_streamer: RTL
========================

Name: obi_string_streamer

Overview:
- OBI manager that sits directly downstream of the user-domain string ROM and consumes its contents.
- On a start pulse it reads 32-bit words sequentially from the ROM over OBI.
- It unpacks each word into bytes, least significant byte first, and presents them on a valid/ready character stream, e.g. toward a UART TX or a debug printer.
- Streaming stops at the first NUL byte or after MaxWords words.

Parameters:
- ObiCfg, obi_pkg::ObiDefaultConfig, OBI configuration (AddrWidth, DataWidth=32, IdWidth).
- obi_req_t, logic, OBI request struct type.
- obi_rsp_t, logic, OBI response struct type.
- BaseAddr, 32'h0, byte address of ROM word 0.
- MaxWords, 8, maximum words fetched per run; must be >=1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  single-cycle pulse that begins a run; ignored unless the FSM is in IDLE.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when a run ends, whether by success or error.
- err_o  out  1  sticky; set when an OBI response has err=1; cleared by start_i accepted in IDLE or by reset.
- obi_req_o  out  obi_req_t  OBI request (manager side).
- obi_rsp_i  in  obi_rsp_t  OBI response.
- char_valid_o  out  1  character valid.
- char_ready_i  in  1  character ready.
- char_o  out  8  character byte.

Behaviour:
- Reset values: all outputs 0; obi_req_o fully zero; FSM in IDLE; word_idx=0; byte_idx=0; buffer=0.
- States: IDLE, REQ, WAIT, DRAIN, FIN.
- IDLE:
  - On start_i: clear err_o, set word_idx=0, go to REQ.
- REQ:
  - req=1, a.addr=BaseAddr+4*word_idx, a.we=0, a.be=4'hF, a.wdata=0, a.aid=0, optional fields 0.
  - All request fields are held stable until gnt.
  - On req&&gnt, go to WAIT; req drops in the next cycle.
  - Exactly one outstanding transaction at any time.
- WAIT:
  - req=0. Any response latency >=1 cycle after grant is tolerated; the ROM answers 2 cycles after grant.
  - On rvalid with r.err=1: set err_o, go to FIN.
  - On rvalid with r.err=0: buffer=r.rdata, byte_idx=0, go to DRAIN.
  - rid is not checked.
- DRAIN:
  - cur=buffer[8*byte_idx+:8].
  - If cur==8'h00: char_valid_o=0 that cycle, go to FIN. The NUL byte is never emitted.
  - Else char_valid_o=1 and char_o=cur.
    - char_o stays stable while valid && !ready.
    - Valid never drops before the handshake completes.
  - On handshake with byte_idx<3: byte_idx++.
  - On handshake with byte_idx==3:
    - if word_idx==MaxWords-1, go to FIN;
    - else word_idx++ and go to REQ.
- FIN:
  - done_o=1 for exactly one cycle, busy_o=1, then IDLE.
- Stray or late responses: rvalid outside WAIT is ignored, e.g. a response arriving after reset.
- Start while busy: start_i in any state other than IDLE is ignored and has no effect on the run.
- Reset mid-operation: synchronous rst_i in any state returns to IDLE at the next edge.
  - No done_o pulse is generated.
  - Any in-flight response is dropped.
- Throughput:
  - Maximum one character per cycle within a word.
  - Word boundary overhead is REQ plus WAIT, at least 2 cycles plus the response latency.
- Address arithmetic: done in AddrWidth bits; wrap-around beyond the address width is not checked.
- Size: character count per run is at most 4*MaxWords.

Test Plan:
- Basic run: ROM model with 2-cycle response latency holding 78656c41, 5f736569, 73276548, 6f724320, 53412063, 43204349, 00706968, 0; char_ready_i=1; pulse start_i -> 27 characters "Alexies_He's Croc ASIC Chip" in order, 7 OBI reads at addresses 0x00..0x18, no read at 0x1C, done_o pulses once, err_o=0.
- Backpressure: same image with char_ready_i toggling pseudo-randomly -> identical 27-byte sequence; char_o stable whenever valid && !ready; no OBI request issued while a word is still draining.
- No terminator: all 8 words 0x41414141, MaxWords=8 -> exactly 32 'A' characters, 8 reads, done_o pulse; a second start_i after done -> another 32 characters.
- Error response: model returns err=1 on word 2 -> 8 characters emitted, err_o=1 held, done_o pulse; next start_i clears err_o.
- Delayed grant / immediate NUL: gnt held low for 5 cycles -> addr and req stable throughout; word 0 = 0x00000000 -> zero characters, done_o pulse, 1 read.
- Disruption: start_i pulsed during DRAIN -> ignored, output sequence unchanged; rst_i asserted in WAIT while the response is pending -> busy_o=0 next cycle, late rvalid ignored, no done_o, fresh start works normally.

Source files
------------

// File: rtl/obi_string_streamer.sv
// OBI string streamer: fetches 32-bit words from the string ROM over OBI and
// emits their bytes, least significant first, on a valid/ready character
// stream until the first NUL byte or MaxWords words.

package obi_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } obi_default_a_chan_t;

    typedef struct packed {
        obi_default_a_chan_t a;
        logic                req;
    } obi_default_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
    } obi_default_r_chan_t;

    typedef struct packed {
        obi_default_r_chan_t r;
        logic                gnt;
        logic                rvalid;
    } obi_default_rsp_t;

endpackage

module obi_string_streamer #(
    parameter obi_pkg::obi_cfg_t ObiCfg    = obi_pkg::ObiDefaultConfig,
    parameter type               obi_req_t = obi_pkg::obi_default_req_t,
    parameter type               obi_rsp_t = obi_pkg::obi_default_rsp_t,
    parameter logic [31:0]       BaseAddr  = 32'h0,
    parameter int unsigned       MaxWords  = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output obi_req_t   obi_req_o,
    input  obi_rsp_t   obi_rsp_i,
    output logic       char_valid_o,
    input  logic       char_ready_i,
    output logic [7:0] char_o
);

    localparam int unsigned AW  = ObiCfg.AddrWidth;
    localparam int unsigned WIW = (MaxWords > 1) ? $clog2(MaxWords) : 1;
    localparam logic [WIW-1:0] LastWord = WIW'(MaxWords - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        FIN
    } state_t;

    state_t         state_q;
    logic [WIW-1:0] word_idx_q;
    logic [1:0]     byte_idx_q;
    logic [31:0]    buffer_q;
    obi_req_t       req_q;
    logic           char_valid_q;
    logic [7:0]     char_q;
    logic           busy_q;
    logic           done_q;
    logic           err_q;

    logic [1:0]     next_byte_idx;
    logic [7:0]     next_byte;
    logic [WIW-1:0] next_word_idx;

    // Read request for a given word: only address, byte enables and req are non-zero.
    function automatic obi_req_t build_req(input logic [WIW-1:0] w);
        obi_req_t r;
        r          = '0;
        r.req      = 1'b1;
        r.a.addr   = AW'(BaseAddr) + (AW'(w) << 2);
        r.a.we     = 1'b0;
        r.a.be     = '1;
        r.a.wdata  = '0;
        return r;
    endfunction

    // Lookahead of the byte that follows the one currently presented.
    always_comb begin
        next_byte_idx = byte_idx_q + 2'd1;
        next_byte     = buffer_q[{next_byte_idx, 3'b000} +: 8];
        next_word_idx = word_idx_q + WIW'(1);
    end

    // Control FSM; every output is a register updated here.
    // char_valid_q is loaded with "next byte is not NUL", so a DRAIN cycle with
    // valid low means the current byte is the terminator and the run ends.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            buffer_q     <= '0;
            req_q        <= '0;
            char_valid_q <= 1'b0;
            char_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        err_q      <= 1'b0;
                        word_idx_q <= '0;
                        busy_q     <= 1'b1;
                        req_q      <= build_req('0);
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    if (obi_rsp_i.gnt) begin
                        req_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (obi_rsp_i.rvalid) begin
                        if (obi_rsp_i.r.err) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            buffer_q     <= obi_rsp_i.r.rdata;
                            byte_idx_q   <= '0;
                            char_q       <= obi_rsp_i.r.rdata[7:0];
                            char_valid_q <= (obi_rsp_i.r.rdata[7:0] != 8'h00);
                            state_q      <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!char_valid_q) begin
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end else if (char_ready_i) begin
                        if (byte_idx_q != 2'd3) begin
                            byte_idx_q   <= next_byte_idx;
                            char_q       <= next_byte;
                            char_valid_q <= (next_byte != 8'h00);
                        end else begin
                            char_valid_q <= 1'b0;
                            char_q       <= '0;
                            if (word_idx_q == LastWord) begin
                                done_q  <= 1'b1;
                                state_q <= FIN;
                            end else begin
                                word_idx_q <= next_word_idx;
                                req_q      <= build_req(next_word_idx);
                                state_q    <= REQ;
                            end
                        end
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign obi_req_o    = req_q;
    assign char_valid_o = char_valid_q;
    assign char_o       = char_q;

endmodule
